// File: rtl/sync_addsub_acc.sv
// Two-stage add/subtract unit with running accumulator, saturation and
// signed/unsigned range detection for the lab board display wrappers.
module sync_addsub_acc #(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic             sat_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid
);

  logic [WIDTH-1:0] s1_a, s1_b;
  logic [1:0]       s1_op;
  logic             s1_sgn, s1_sat, s1_valid;

  logic [WIDTH-1:0] opx, opy, res;
  logic [WIDTH:0]   raw;
  logic             raw_carry, raw_ovf, range_err;

  // op[1] selects the accumulator as first operand; op[0] selects subtract.
  // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
  always_comb begin
    opx = s1_op[1] ? acc  : s1_a;
    opy = s1_op[1] ? s1_a : s1_b;
    if (s1_op[0]) begin
      raw       = {1'b0, opx} + {1'b0, ~opy} + {{WIDTH{1'b0}}, 1'b1};
      raw_carry = ~raw[WIDTH];
      raw_ovf   = (opx[WIDTH-1] != opy[WIDTH-1]) && (raw[WIDTH-1] != opx[WIDTH-1]);
    end else begin
      raw       = {1'b0, opx} + {1'b0, opy};
      raw_carry = raw[WIDTH];
      raw_ovf   = (opx[WIDTH-1] == opy[WIDTH-1]) && (raw[WIDTH-1] != opx[WIDTH-1]);
    end
    range_err = s1_sgn ? raw_ovf : raw_carry;
    res       = raw[WIDTH-1:0];
    if (s1_sat && range_err) begin
      // A signed overflow always has the true sign of the first operand.
      if (s1_sgn)
        res = opx[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        res = s1_op[0] ? '0 : '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what lets back-to-back ops read acc.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_sgn     <= 1'b0;
      s1_sat     <= 1'b0;
      s1_valid   <= 1'b0;
      sum        <= '0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
      out_valid  <= 1'b0;
    end else begin
      s1_a      <= a;
      s1_b      <= b;
      s1_op     <= op;
      s1_sgn    <= sgn;
      s1_sat    <= sat_en;
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum      <= res;
        carry    <= raw_carry;
        overflow <= raw_ovf;
      end
      // Clear wins over a same-edge accumulator write.
      if (acc_clr) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else if (s1_valid) begin
        acc        <= res;
        ovf_sticky <= ovf_sticky | range_err;
      end
    end
  end

endmodule

// File: tb/tb_sync_addsub_acc.sv
// Directed-vector bench for sync_addsub_acc at WIDTH=4 with hand-computed
// expectations for arithmetic, saturation, accumulation, clear and reset.
module tb_sync_addsub_acc;

  logic       clk = 1'b0;
  logic       reset, in_valid, sgn, sat_en, acc_clr;
  logic [1:0] op;
  logic [3:0] a, b;
  logic [3:0] sum, acc;
  logic       carry, overflow, ovf_sticky, out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_addsub_acc #(.WIDTH(4)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .sgn       (sgn),
    .sat_en    (sat_en),
    .acc_clr   (acc_clr),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .ovf_sticky(ovf_sticky),
    .acc       (acc),
    .out_valid (out_valid)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one op for a single edge, then wait for the result edge (+1ns).
  task automatic issue(input logic [1:0] o, input logic [3:0] ia, input logic [3:0] ib,
                       input logic s, input logic st);
    @(negedge clk);
    op = o; a = ia; b = ib; sgn = s; sat_en = st; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk); acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sum !== 4'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if (acc !== 4'h0) begin errors++; $display("FAIL reset_acc got=%h exp=0", acc); end
    checks++; if ({carry, overflow, ovf_sticky, out_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {carry, overflow, ovf_sticky, out_valid}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned_add();
    issue(2'b00, 4'd7, 4'd9, 1'b0, 1'b0);
    checks++; if (sum !== 4'h0) begin errors++; $display("FAIL uadd_sum got=%h exp=0", sum); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL uadd_carry got=%b exp=1", carry); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL uadd_ovf got=%b exp=0", overflow); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL uadd_sticky got=%b exp=1", ovf_sticky); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uadd_valid got=%b exp=1", out_valid); end
    issue(2'b00, 4'd7, 4'd9, 1'b0, 1'b1);
    checks++; if (sum !== 4'hF) begin errors++; $display("FAIL uadd_sat_sum got=%h exp=F", sum); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL uadd_sat_carry got=%b exp=1", carry); end
  endtask

  task automatic test_signed_add();
    issue(2'b00, 4'd5, 4'd4, 1'b1, 1'b0);
    checks++; if (sum !== 4'h9) begin errors++; $display("FAIL sadd_sum got=%h exp=9", sum); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sadd_ovf got=%b exp=1", overflow); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sadd_carry got=%b exp=0", carry); end
    issue(2'b00, 4'd5, 4'd4, 1'b1, 1'b1);
    checks++; if (sum !== 4'h7) begin errors++; $display("FAIL sadd_sat_pos got=%h exp=7", sum); end
    issue(2'b00, 4'h8, 4'hF, 1'b1, 1'b1);
    checks++; if (sum !== 4'h8) begin errors++; $display("FAIL sadd_sat_neg got=%h exp=8", sum); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sadd_neg_ovf got=%b exp=1", overflow); end
  endtask

  task automatic test_subtract();
    issue(2'b01, 4'd2, 4'd5, 1'b0, 1'b0);
    checks++; if (sum !== 4'hD) begin errors++; $display("FAIL sub_sum got=%h exp=D", sum); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL sub_borrow got=%b exp=1", carry); end
    issue(2'b01, 4'd2, 4'd5, 1'b0, 1'b1);
    checks++; if (sum !== 4'h0) begin errors++; $display("FAIL sub_sat got=%h exp=0", sum); end
    pulse_clr();
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got=%b exp=0", ovf_sticky); end
    issue(2'b01, 4'd5, 4'd2, 1'b0, 1'b0);
    checks++; if (sum !== 4'h3) begin errors++; $display("FAIL sub_ok_sum got=%h exp=3", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sub_ok_borrow got=%b exp=0", carry); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sub_ok_sticky got=%b exp=0", ovf_sticky); end
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    @(negedge clk);
    op = 2'b00; a = 4'd3; b = 4'd2; sgn = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 op = 2'b10; a = 4'd4;
    @(posedge clk); #1;
    checks++; if ({out_valid, sum, acc} !== {1'b1, 4'd5, 4'd5}) begin
      errors++; $display("FAIL b2b_1 got=v%b s%h a%h exp=v1 s5 a5", out_valid, sum, acc); end
    op = 2'b11; a = 4'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if ({out_valid, sum, acc} !== {1'b1, 4'd9, 4'd9}) begin
      errors++; $display("FAIL b2b_2 got=v%b s%h a%h exp=v1 s9 a9", out_valid, sum, acc); end
    @(posedge clk); #1;
    checks++; if ({out_valid, sum, acc} !== {1'b1, 4'd8, 4'd8}) begin
      errors++; $display("FAIL b2b_3 got=v%b s%h a%h exp=v1 s8 a8", out_valid, sum, acc); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_clear_collision();
    pulse_clr();
    issue(2'b10, 4'd6, 4'd0, 1'b0, 1'b0);
    checks++; if (acc !== 4'd6) begin errors++; $display("FAIL coll_setup got=%h exp=6", acc); end
    @(negedge clk);
    op = 2'b10; a = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    checks++; if (sum !== 4'd7) begin errors++; $display("FAIL coll_sum got=%h exp=7", sum); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL coll_valid got=%b exp=1", out_valid); end
    checks++; if (acc !== 4'd0) begin errors++; $display("FAIL coll_acc got=%h exp=0", acc); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL coll_sticky got=%b exp=0", ovf_sticky); end
    issue(2'b10, 4'd2, 4'd0, 1'b0, 1'b0);
    checks++; if (acc !== 4'd2) begin errors++; $display("FAIL coll_next got=%h exp=2", acc); end
  endtask

  task automatic test_reset_mid_op();
    issue(2'b00, 4'd7, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    op = 2'b00; a = 4'd1; b = 4'd1; sgn = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checks++; if ({sum, acc, carry, overflow, ovf_sticky, out_valid} !== 12'h000) begin
      errors++; $display("FAIL rst_mid_outputs got=s%h a%h c%b o%b st%b v%b exp=all0",
                         sum, acc, carry, overflow, ovf_sticky, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_nopulse got=%b exp=0", out_valid); end
    @(negedge clk);
    op = 2'b00; a = 4'd3; b = 4'd4; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_lat_early got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++; if ({out_valid, sum, acc} !== {1'b1, 4'd7, 4'd7}) begin
      errors++; $display("FAIL rst_lat_result got=v%b s%h a%h exp=v1 s7 a7", out_valid, sum, acc); end
  endtask

  initial begin
    in_valid = 1'b0; op = 2'b00; sgn = 1'b0; sat_en = 1'b0; acc_clr = 1'b0;
    a = 4'h0; b = 4'h0; reset = 1'b1;
    test_reset();
    test_unsigned_add();
    test_signed_add();
    test_subtract();
    test_back_to_back();
    test_clear_collision();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_addsub_acc.md
# sync_addsub_acc

Parametrised, pipelined add/subtract unit with a running accumulator, saturation and signed/unsigned range detection. It is the next-generation replacement for the fixed 4-bit registered adder/subtractor used in the lab board tops. Switch or host operands enter through a valid-qualified input stage. Results, flags and the accumulator drive the hex display and LED wrappers.

## Interface
- `WIDTH`, 4: operand, result and accumulator width in bits (≥2).
- `CLOCK_50`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and controls are valid this cycle.
- `op`  in  2  operation select:
  - 00: A+B
  - 01: A−B
  - 10: ACC+A
  - 11: ACC−A
- `sgn`  in  1  1 = two's-complement interpretation; 0 = unsigned.
- `sat_en`  in  1  1 = saturate out-of-range results.
- `acc_clr`  in  1  clear accumulator and sticky flag (not pipelined).
- `a`, `b`  in  WIDTH each  operands.
- `sum`  out  WIDTH  registered result.
- `carry`  out  1  add: carry out of MSB; sub: borrow (1 when minuend < subtrahend, unsigned).
- `overflow`  out  1  signed overflow of the operation.
- `ovf_sticky`  out  1  set by any range error since last clear.
- `acc`  out  WIDTH  accumulator register.
- `out_valid`  out  1  one-cycle pulse marking a new result.

## Operation
- Stage 1 (input register): on every edge it captures `a`, `b`, `op`, `sgn`, `sat_en` and `in_valid` into s1 registers, unconditionally.
- Stage 2 (execute register): when s1 valid is high, it computes from the s1 registers and the current `acc`.
  - Minuend/augend is `a` for op 0x and `acc` for op 1x.
  - Second operand is `b` for op 0x and `a` for op 1x.
- Arithmetic is done at WIDTH+1 bits:
  - `carry` = bit WIDTH of the add; for subtract it is the inverted carry of minuend + ~subtrahend + 1.
  - `overflow` = operands of equal sign (add) or opposite sign (sub) with the result sign differing from the first operand.
- Range error: `overflow` when sgn=1; `carry` when sgn=0.
- Saturation applies when sat_en=1 and a range error occurs:
  - sgn=0: add → all ones, sub → 0.
  - sgn=1: clamps to 2^(WIDTH−1)−1 if the true result is positive, or −2^(WIDTH−1) if negative.
- `carry` and `overflow` always report the raw condition, even when the result is saturated.
- On a valid stage-2 edge:
  - `sum` and `acc` load the (possibly saturated) result.
  - `carry` and `overflow` update.
  - `out_valid` = 1.
  - `ovf_sticky` |= range error.
- When s1 valid is low: `sum`, `carry`, `overflow` and `acc` hold, and `out_valid` = 0.
- `acc_clr` at an edge: `acc` ← 0 and `ovf_sticky` ← 0.
  - It has priority over a simultaneous stage-2 write to `acc`/`ovf_sticky`.
  - `sum`, `carry`, `overflow` and `out_valid` still update normally that edge.
- `reset`: all s1 registers, `sum`, `carry`, `overflow`, `ovf_sticky`, `acc` and `out_valid` go to 0 at the edge. Reset has priority over `acc_clr` and any in-flight operation; the in-flight operation is discarded.

## Timing
- Latency is 2 edges: `in_valid` sampled at edge N gives results visible after edge N+1, with `out_valid` high for exactly the cycle between N+1 and N+2.
- Throughput is one operation per clock. Back-to-back accumulate ops need no stall: the op sampled at N+1 sees `acc` written at N+1.
- If `acc_clr` is asserted at edge N+1 while an ACC op is in s1, that op still uses the pre-clear `acc` (combinational read at N+1). The op sampled at N+1 sees `acc` = 0.
- `acc_clr` asserted at edge N affects an op sampled at edge N only if that op executes at N+1, where it then reads 0.
- Reset asserted for one edge with an op in s1: no `out_valid` pulse follows.

## Test plan
- Unsigned add, WIDTH=4, sgn=0:
  - a=7, b=9, sat_en=0 → sum=0, carry=1, overflow=0, ovf_sticky=1.
  - Same with sat_en=1 → sum=F, carry=1.
- Signed add, sgn=1:
  - a=5, b=4, sat_en=0 → sum=9, overflow=1.
  - Same with sat_en=1 → sum=7.
  - a=8, b=F with sat_en=1 → sum=8, overflow=1.
- Subtract, op=01:
  - a=2, b=5, sgn=0 → sum=D, carry=1; with sat_en=1 → sum=0.
  - a=5, b=2 → sum=3, carry=0, ovf_sticky unchanged.
- Back-to-back accumulate, in_valid high on 3 consecutive edges:
  - (op00 a=3 b=2), (op10 a=4), (op11 a=1).
  - Expected: out_valid high 3 consecutive cycles; sum/acc = 5, 9, 8.
- Clear collision: acc_clr asserted on the same edge a valid op writes, with acc=6 and op10 a=1.
  - Expected: sum=7, out_valid=1, acc=0, ovf_sticky=0.
  - Next op10 a=2 → acc=2.
- Reset mid-operation: op sampled at edge N, reset at N+1.
  - Expected: no out_valid pulse; all outputs 0 after N+1.
  - The next op after reset deasserts behaves normally with 2-edge latency.
